// File: rtl/fifo_bram_sync_if.sv
// Stream handshake bundle for fifo_bram_sync: write side (s_*) and read side (m_*).
// master = producer/consumer environment, slave = the FIFO.
interface fifo_bram_sync_if #(
  parameter int unsigned DATA = 8
);
  logic            s_valid;
  logic            s_ready;
  logic [DATA-1:0] s_data;
  logic            m_valid;
  logic            m_ready;
  logic [DATA-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/fifo_bram_sync.sv
// Synchronous FIFO on one simple-dual-port block RAM with a two-entry prefetch
// stage (output register + skid) giving first-word-fall-through on the read side.
module fifo_bram_sync #(
  parameter int unsigned DATA          = 8,
  parameter int unsigned ADDR          = 12,
  parameter int unsigned AFULL_THRESH  = (1 << ADDR) - 4,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  fifo_bram_sync_if.slave       bus,
  output logic [ADDR:0]         level,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam logic [ADDR:0] CAP_W = {1'b1, {ADDR{1'b0}}};
  localparam logic [ADDR:0] AF_W  = (ADDR + 1)'(AFULL_THRESH);
  localparam logic [ADDR:0] AE_W  = (ADDR + 1)'(AEMPTY_THRESH);
  localparam logic [ADDR:0] ONE_W = (ADDR + 1)'(1);

  logic [DATA-1:0] mem [0:(1 << ADDR) - 1];

  logic [ADDR:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR-1:0] rd_addr_q;
  logic            inflight_q;
  logic            out_v_q, out_v_d;
  logic [DATA-1:0] out_q, out_d;
  logic            skid_v_q, skid_v_d;
  logic [DATA-1:0] skid_q, skid_d;
  logic [ADDR:0]   level_q, level_d;
  logic            af_q, ae_q;

  logic            push, pop, issue;
  logic [1:0]      occ;
  logic [DATA-1:0] ram_rdata;

  assign bus.s_ready  = (level_q < CAP_W) && !flush;
  assign bus.m_valid  = out_v_q;
  assign bus.m_data   = out_q;
  assign level        = level_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

  assign push = bus.s_valid && bus.s_ready;
  assign pop  = out_v_q && bus.m_ready;

  // Words that will sit in output+skid after this edge; a new read is issued only
  // if that leaves room for it to land next cycle, so the skid can never overflow.
  assign occ   = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, inflight_q} - {1'b0, pop};
  assign issue = (wr_ptr_q != rd_ptr_q) && (occ < 2'd2) && !flush;

  assign ram_rdata = mem[rd_addr_q];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[ADDR-1:0]] <= bus.s_data;
    if (issue) rd_addr_q <= rd_ptr_q[ADDR-1:0];
  end

  always_comb begin
    out_v_d  = out_v_q;
    out_d    = out_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (pop) begin
      out_v_d  = skid_v_q;
      if (skid_v_q) out_d = skid_q;
      skid_v_d = 1'b0;
    end
    if (inflight_q) begin
      if (!out_v_d) begin
        out_v_d = 1'b1;
        out_d   = ram_rdata;
      end else begin
        skid_v_d = 1'b1;
        skid_d   = ram_rdata;
      end
    end
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + ONE_W;
    else if (pop && !push) level_d = level_q - ONE_W;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      out_v_q    <= 1'b0;
      out_q      <= '0;
      skid_v_q   <= 1'b0;
      skid_q     <= '0;
      level_q    <= '0;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      out_v_q    <= 1'b0;
      out_q      <= '0;
      skid_v_q   <= 1'b0;
      skid_q     <= '0;
      level_q    <= '0;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + ONE_W;
      if (issue) rd_ptr_q <= rd_ptr_q + ONE_W;
      inflight_q <= issue;
      out_v_q    <= out_v_d;
      out_q      <= out_d;
      skid_v_q   <= skid_v_d;
      skid_q     <= skid_d;
      level_q    <= level_d;
      af_q       <= (level_d >= AF_W);
      ae_q       <= (level_d <= AE_W);
    end
  end

endmodule

// File: tb/tb_fifo_bram_sync.sv
// Scoreboard bench for fifo_bram_sync (ADDR=4, CAP=16, AFULL=12, AEMPTY=4).
module tb_fifo_bram_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [4:0] level;
  logic       af, ae;

  fifo_bram_sync_if #(.DATA(8)) bus ();

  fifo_bram_sync #(
    .DATA(8), .ADDR(4), .AFULL_THRESH(12), .AEMPTY_THRESH(4)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .level(level), .almost_full(af), .almost_empty(ae)
  );

  always #5 clk = ~clk;

  logic [7:0] sb[$];
  int lvl   = 0;
  int tests = 0;
  int fails = 0;
  int pops  = 0;

  // One clock cycle: drive at negedge, account push/pop before the edge, check after it.
  task automatic drive_cycle(input logic sv, input logic [7:0] sd, input logic mr,
                             input logic fl, output logic pushed);
    logic       exp_ready;
    logic [7:0] head;
    bus.s_valid = sv;
    bus.s_data  = sd;
    bus.m_ready = mr;
    flush       = fl;
    #1;
    exp_ready = (lvl < 16) && !fl;
    tests++;
    if (bus.s_ready !== exp_ready) begin
      fails++;
      $display("FAIL s_ready: got %b expected %b (model level %0d)", bus.s_ready, exp_ready, lvl);
    end
    pushed = sv && exp_ready;
    if (bus.m_valid === 1'b1 && mr) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL spurious_word: got m_data %h expected no word (scoreboard empty)", bus.m_data);
      end else begin
        head = sb.pop_front();
        lvl--;
        if (bus.m_data !== head) begin
          fails++;
          $display("FAIL pop_data: got %h expected %h", bus.m_data, head);
        end
      end
      pops++;
    end
    if (pushed) begin
      sb.push_back(sd);
      lvl++;
    end
    if (fl) begin
      sb.delete();
      lvl = 0;
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (level !== 5'(lvl)) begin
      fails++;
      $display("FAIL level: got %0d expected %0d", level, lvl);
    end
    tests++;
    if (af !== (lvl >= 12) || ae !== (lvl <= 4)) begin
      fails++;
      $display("FAIL flags: got af=%b ae=%b expected af=%b ae=%b (level %0d)",
               af, ae, (lvl >= 12), (lvl <= 4), lvl);
    end
    if (lvl == 0) begin
      tests++;
      if (bus.m_valid !== 1'b0) begin
        fails++;
        $display("FAIL empty_m_valid: got %b expected 0", bus.m_valid);
      end
    end
  endtask

  task automatic apply_reset();
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    flush       = 1'b0;
    reset       = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    lvl = 0;
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    flush       = 1'b0;
    reset       = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (level !== 5'd0 || bus.m_valid !== 1'b0 || bus.m_data !== 8'h00 ||
        af !== 1'b0 || ae !== 1'b1 || bus.s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: got level=%0d m_valid=%b m_data=%h af=%b ae=%b s_ready=%b expected 0 0 00 0 1 1",
               level, bus.m_valid, bus.m_data, af, ae, bus.s_ready);
    end
    reset = 1'b0;
    sb.delete();
    lvl = 0;
  endtask

  task automatic test_single();
    logic p;
    drive_cycle(1'b1, 8'hA5, 1'b1, 1'b0, p);
    tests++;
    if (bus.m_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_e0: got m_valid %b expected 0", bus.m_valid);
    end
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, p);
    tests++;
    if (bus.m_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_e1: got m_valid %b expected 0", bus.m_valid);
    end
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, p);
    tests++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hA5) begin
      fails++;
      $display("FAIL latency_e2: got m_valid %b m_data %h expected 1 a5", bus.m_valid, bus.m_data);
    end
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, p);
    tests++;
    if (level !== 5'd0 || ae !== 1'b1) begin
      fails++;
      $display("FAIL single_drain: got level %0d ae %b expected 0 1", level, ae);
    end
  endtask

  task automatic test_fill();
    logic p;
    int   n;
    int   p0;
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b0, p);
    tests++;
    if (bus.s_ready !== 1'b0 || level !== 5'd16 || af !== 1'b1) begin
      fails++;
      $display("FAIL full_state: got s_ready %b level %0d af %b expected 0 16 1", bus.s_ready, level, af);
    end
    drive_cycle(1'b1, 8'hEE, 1'b0, 1'b0, p);
    tests++;
    if (level !== 5'd16) begin
      fails++;
      $display("FAIL overflow_push: got level %0d expected 16", level);
    end
    p0 = pops;
    n  = 0;
    while (sb.size() > 0 && n < 64) begin
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, p);
      n++;
    end
    tests++;
    if (sb.size() != 0 || pops - p0 != 16) begin
      fails++;
      $display("FAIL fill_drain: got %0d words out, %0d left expected 16 out, 0 left", pops - p0, sb.size());
    end
  endtask

  task automatic test_random();
    logic p;
    int   sent = 0;
    int   cyc  = 0;
    while ((sent < 100 || sb.size() > 0) && cyc < 3000) begin
      drive_cycle((sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0, 8'(sent + 8'h40),
                  1'($urandom_range(0, 1)), 1'b0, p);
      if (p) sent++;
      cyc++;
    end
    tests++;
    if (sent != 100 || sb.size() != 0) begin
      fails++;
      $display("FAIL random_stream: got sent %0d pending %0d expected 100 0", sent, sb.size());
    end
  endtask

  task automatic test_wrap();
    logic p;
    int   p0;
    bit   started = 0;
    apply_reset();
    p0 = pops;
    for (int c = 0; c < 60; c++) begin
      drive_cycle(c < 40, 8'(c), 1'b1, 1'b0, p);
      if (bus.m_valid === 1'b1) started = 1;
      if (started && (pops - p0) < 40) begin
        tests++;
        if (bus.m_valid !== 1'b1) begin
          fails++;
          $display("FAIL wrap_bubble: got m_valid %b expected 1 after %0d words", bus.m_valid, pops - p0);
        end
      end
    end
    tests++;
    if (pops - p0 != 40 || sb.size() != 0) begin
      fails++;
      $display("FAIL wrap_count: got %0d words expected 40", pops - p0);
    end
  endtask

  task automatic test_flush();
    logic p;
    int   n;
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, p);
    tests++;
    if (level !== 5'd10) begin
      fails++;
      $display("FAIL flush_pre_level: got %0d expected 10", level);
    end
    drive_cycle(1'b1, 8'hF0, 1'b0, 1'b1, p);
    tests++;
    if (level !== 5'd0 || bus.m_valid !== 1'b0 || ae !== 1'b1) begin
      fails++;
      $display("FAIL flush_state: got level %0d m_valid %b ae %b expected 0 0 1", level, bus.m_valid, ae);
    end
    drive_cycle(1'b1, 8'h11, 1'b1, 1'b0, p);
    n = 0;
    while ((sb.size() > 0 || n < 4) && n < 12) begin
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, p);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL flush_after: got %0d words pending expected 0", sb.size());
    end
  endtask

  task automatic test_async_reset();
    logic p;
    int   n;
    int   p0;
    for (int i = 0; i < 7; i++) drive_cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, p);
    tests++;
    if (level !== 5'd7) begin
      fails++;
      $display("FAIL areset_pre_level: got %0d expected 7", level);
    end
    bus.s_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (level !== 5'd0 || bus.m_valid !== 1'b0 || bus.m_data !== 8'h00 || ae !== 1'b1 || af !== 1'b0) begin
      fails++;
      $display("FAIL areset_immediate: got level %0d m_valid %b m_data %h ae %b af %b expected 0 0 00 1 0",
               level, bus.m_valid, bus.m_data, ae, af);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    lvl = 0;
    p0  = pops;
    drive_cycle(1'b1, 8'h3C, 1'b1, 1'b0, p);
    n = 0;
    while ((sb.size() > 0 || n < 4) && n < 12) begin
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, p);
      n++;
    end
    tests++;
    if (pops - p0 != 1 || sb.size() != 0) begin
      fails++;
      $display("FAIL areset_after: got %0d words out expected 1 (0x3c)", pops - p0);
    end
  endtask

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_random();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
